// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: instruction fetch stage of the RISC-V core.
// Owns the PC and issues in-order word fetches over a req/gnt + rvalid
// interface. Each request's PC is remembered in a 2-entry tag FIFO, and
// returned words go into a 2-entry queue that feeds decode via valid/ready.
// A redirect flushes the queue and tag FIFO. Responses that are still owed
// at that point are counted and discarded when they return.
// Optional feature: define IFU_PERF_CNT_EN to add the perf_fetched_o and
// perf_stall_o counters.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [6:0]  opcode_o,
  input  logic        inst_ready_i
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched_o,
  output logic [31:0] perf_stall_o
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q;

  // PC and memory bookkeeping
  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;   // requests granted but not yet answered
  logic [1:0]  drop_q, drop_d;     // stale responses still to be discarded

  // In-order tag FIFO holding the PC of every live request
  logic [31:0] tag0_q, tag0_d;
  logic [31:0] tag1_q, tag1_d;
  logic        tag_wp_q, tag_wp_d;
  logic        tag_rp_q, tag_rp_d;

  // Instruction queue: head feeds the outputs, tail is the second slot
  logic [31:0] head_inst_q, head_inst_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] tail_inst_q, tail_inst_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  logic [1:0]  q_cnt_q, q_cnt_d;

  // Control
  logic        run_s;
  logic [2:0]  inflight_s;
  logic        credit_s;
  logic        req_s;
  logic        gnt_s;
  logic        flush_s;
  logic        q_valid_s;
  logic        pop_s;
  logic        discard_s;
  logic        accept_s;
  logic [31:0] tag_pc_s;
  logic [31:0] redirect_tgt_s;
  logic        unused_rpc_lsb_s;

  assign run_s      = (state_q == ST_RUN);
  // A request is allowed only if every outstanding response, including stale
  // ones still being drained, is guaranteed to have a queue slot.
  assign inflight_s = {1'b0, outst_q} + {1'b0, q_cnt_q};
  assign credit_s   = (inflight_s < 3'd2);
  assign req_s      = run_s & credit_s & ~redirect_i;
  assign gnt_s      = req_s & imem_gnt_i;
  // A redirect in IDLE only moves the PC; it does not flush.
  assign flush_s    = redirect_i & run_s;
  assign q_valid_s  = (q_cnt_q != 2'd0);
  assign pop_s      = q_valid_s & inst_ready_i;
  assign discard_s  = imem_rvalid_i & (drop_q != 2'd0);
  assign accept_s   = imem_rvalid_i & (drop_q == 2'd0) & ~flush_s;
  assign tag_pc_s   = tag_rp_q ? tag1_q : tag0_q;
  assign redirect_tgt_s   = {redirect_pc_i[31:2], 2'b00};
  assign unused_rpc_lsb_s = ^redirect_pc_i[1:0];

  assign imem_req_o   = req_s;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = q_valid_s;
  assign inst_o       = head_inst_q;
  assign inst_pc_o    = head_pc_q;
  assign opcode_o     = head_inst_q[6:0];

  // Outstanding count: +1 on grant, -1 on any response, unchanged on both
  always_comb begin
    outst_d = outst_q;
    case ({gnt_s, imem_rvalid_i})
      2'b10:   outst_d = outst_q + 2'd1;
      2'b01:   outst_d = outst_q - 2'd1;
      default: outst_d = outst_q;
    endcase
  end

  // Drop count: on a flush, every response still owed becomes stale
  always_comb begin
    if (flush_s) begin
      drop_d = outst_d;
    end else if (discard_s) begin
      drop_d = drop_q - 2'd1;
    end else begin
      drop_d = drop_q;
    end
  end

  // Next PC: a redirect wins, otherwise advance by one word on each grant
  always_comb begin
    if (redirect_i) begin
      pc_d = redirect_tgt_s;
    end else if (gnt_s) begin
      pc_d = pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // Tag FIFO: push the PC of each grant, pop on each accepted response
  always_comb begin
    tag0_d   = tag0_q;
    tag1_d   = tag1_q;
    tag_wp_d = tag_wp_q;
    tag_rp_d = tag_rp_q;
    if (flush_s) begin
      tag_wp_d = 1'b0;
      tag_rp_d = 1'b0;
    end else begin
      if (gnt_s) begin
        if (tag_wp_q) begin
          tag1_d = pc_q;
        end else begin
          tag0_d = pc_q;
        end
        tag_wp_d = ~tag_wp_q;
      end else begin
        tag_wp_d = tag_wp_q;
      end
      if (accept_s) begin
        tag_rp_d = ~tag_rp_q;
      end else begin
        tag_rp_d = tag_rp_q;
      end
    end
  end

  // Instruction queue: push accepted responses, pop on decode handshake
  always_comb begin
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    tail_inst_d = tail_inst_q;
    tail_pc_d   = tail_pc_q;
    q_cnt_d     = q_cnt_q;
    if (flush_s) begin
      q_cnt_d = 2'd0;
    end else begin
      case (q_cnt_q)
        2'd0: begin
          if (accept_s) begin
            head_inst_d = imem_rdata_i;
            head_pc_d   = tag_pc_s;
            q_cnt_d     = 2'd1;
          end else begin
            q_cnt_d     = 2'd0;
          end
        end
        2'd1: begin
          case ({accept_s, pop_s})
            2'b11: begin
              head_inst_d = imem_rdata_i;
              head_pc_d   = tag_pc_s;
            end
            2'b10: begin
              tail_inst_d = imem_rdata_i;
              tail_pc_d   = tag_pc_s;
              q_cnt_d     = 2'd2;
            end
            2'b01:   q_cnt_d = 2'd0;
            default: q_cnt_d = 2'd1;
          endcase
        end
        2'd2: begin
          case ({accept_s, pop_s})
            2'b11: begin
              head_inst_d = tail_inst_q;
              head_pc_d   = tail_pc_q;
              tail_inst_d = imem_rdata_i;
              tail_pc_d   = tag_pc_s;
            end
            2'b01: begin
              head_inst_d = tail_inst_q;
              head_pc_d   = tail_pc_q;
              q_cnt_d     = 2'd1;
            end
            default: q_cnt_d = 2'd2;
          endcase
        end
        default: q_cnt_d = 2'd0;
      endcase
    end
  end

  // Fetch enable FSM: RUN follows start_i, IDLE stops new requests only
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_q <= start_i ? ST_RUN : ST_IDLE;
        ST_RUN:  state_q <= start_i ? ST_RUN : ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Datapath registers: PC, counters, tag FIFO and instruction queue
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q        <= RESET_PC;
      outst_q     <= 2'd0;
      drop_q      <= 2'd0;
      tag0_q      <= 32'd0;
      tag1_q      <= 32'd0;
      tag_wp_q    <= 1'b0;
      tag_rp_q    <= 1'b0;
      head_inst_q <= 32'd0;
      head_pc_q   <= 32'd0;
      tail_inst_q <= 32'd0;
      tail_pc_q   <= 32'd0;
      q_cnt_q     <= 2'd0;
    end else begin
      pc_q        <= pc_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
      tag0_q      <= tag0_d;
      tag1_q      <= tag1_d;
      tag_wp_q    <= tag_wp_d;
      tag_rp_q    <= tag_rp_d;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
      tail_inst_q <= tail_inst_d;
      tail_pc_q   <= tail_pc_d;
      q_cnt_q     <= q_cnt_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  // Performance counters: decode handshakes and decode stall cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (pop_s) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end else begin
        perf_fetched_q <= perf_fetched_q;
      end
      if (q_valid_s & ~inst_ready_i) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end else begin
        perf_stall_q <= perf_stall_q;
      end
    end
  end

  assign perf_fetched_o = perf_fetched_q;
  assign perf_stall_o   = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: random memory latency/grant,
// decode back-pressure and redirects, checked every cycle against a
// queue-based behavioural model, plus hand-computed literal expectations.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, imem_gnt_i, imem_rvalid_i, redirect_i, inst_ready_i;
  logic [31:0] imem_rdata_i, redirect_pc_i;
  logic        imem_req_o, inst_valid_o;
  logic [31:0] imem_addr_o, inst_o, inst_pc_o;
  logic [6:0]  opcode_o;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched_o, perf_stall_o;
  logic [31:0] w_perf_f, w_perf_s;
`endif

  // Second instance with a wrapping reset PC and a trivial memory
  logic        w_start, w_req, w_rvalid, w_valid;
  logic [31:0] w_addr, w_inst, w_pc;
  logic [6:0]  w_opc;
  logic [31:0] w_addrs[$];
  bit          w_stopped;
  int          w_late;

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int gnt_pct = 100;
  int lat_lo  = 1;
  int lat_hi  = 1;

  // Behavioural model state (values of the current cycle's registers)
  bit          m_run;
  logic [31:0] m_pc;
  int          m_outst, m_drop;
  logic [31:0] tagq[$];
  logic [31:0] qpc[$];
  logic [31:0] qinst[$];
  logic [31:0] m_fetched, m_stall;
  // Memory: in-order pending responses
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o),
    .opcode_o      (opcode_o),
    .inst_ready_i  (inst_ready_i)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched_o(perf_fetched_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (w_start),
    .imem_req_o    (w_req),
    .imem_addr_o   (w_addr),
    .imem_gnt_i    (1'b1),
    .imem_rvalid_i (w_rvalid),
    .imem_rdata_i  (32'h0000_0013),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0000_0000),
    .inst_valid_o  (w_valid),
    .inst_o        (w_inst),
    .inst_pc_o     (w_pc),
    .opcode_o      (w_opc),
    .inst_ready_i  (1'b1)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched_o(w_perf_f),
    .perf_stall_o  (w_perf_s)
`endif
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Trivial one-cycle responder for the wrap instance
  always @(posedge clk or posedge rst) begin
    if (rst) w_rvalid <= 1'b0;
    else     w_rvalid <= w_req;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0000)      return 32'h00A0_0093;
    else if (a == 32'h0000_0004) return 32'h0010_8113;
    else                         return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function void model_reset();
    m_run = 1'b0;
    m_pc = 32'h0000_0000;
    m_outst = 0;
    m_drop = 0;
    tagq.delete();
    qpc.delete();
    qinst.delete();
    m_fetched = 32'd0;
    m_stall = 32'd0;
  endfunction

  // Compare process: check outputs against the model, then advance it
  always @(negedge clk) begin
    bit exp_req;
    bit g;
    bit pop;
    int owed;
    if (rst) begin
      model_reset();
      mq_addr.delete();
      mq_due.delete();
    end else begin
      exp_req = m_run && ((m_outst + qpc.size()) < 2) && !redirect_i;
      chk("imem_req", 32'(imem_req_o), 32'(exp_req));
      chk("imem_addr", imem_addr_o, m_pc);
      chk("inst_valid", 32'(inst_valid_o), 32'(qpc.size() != 0));
      if (qpc.size() != 0) begin
        chk("inst_pc", inst_pc_o, qpc[0]);
        chk("inst", inst_o, qinst[0]);
        chk("opcode", 32'(opcode_o), 32'(qinst[0][6:0]));
      end
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetched", perf_fetched_o, m_fetched);
      chk("perf_stall", perf_stall_o, m_stall);
`endif
      // memory environment reacts to what the DUT actually did
      if (imem_req_o && imem_gnt_i) begin
        mq_addr.push_back(imem_addr_o);
        mq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
      end
      if (imem_rvalid_i && mq_addr.size() != 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      // model step
      g   = exp_req && imem_gnt_i;
      pop = (qpc.size() != 0) && inst_ready_i;
      if (pop) m_fetched = m_fetched + 32'd1;
      if (qpc.size() != 0 && !inst_ready_i) m_stall = m_stall + 32'd1;
      if (redirect_i && m_run) begin
        owed = m_outst + int'(g) - int'(imem_rvalid_i);
        m_outst = owed;
        m_drop = owed;
        qpc.delete();
        qinst.delete();
        tagq.delete();
        m_pc = {redirect_pc_i[31:2], 2'b00};
      end else begin
        if (pop) begin
          void'(qpc.pop_front());
          void'(qinst.pop_front());
        end
        if (g) begin
          tagq.push_back(m_pc);
          m_pc = m_pc + 32'd4;
          m_outst++;
        end
        if (imem_rvalid_i) begin
          m_outst--;
          if (m_drop > 0) begin
            m_drop--;
          end else if (tagq.size() != 0) begin
            qpc.push_back(tagq.pop_front());
            qinst.push_back(imem_rdata_i);
          end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL model_tag: actual=rvalid_with_no_request required=none");
          end
        end
        if (redirect_i) m_pc = {redirect_pc_i[31:2], 2'b00};
      end
      m_run = start_i;
      // wrap instance grant log (grant is tied high)
      if (w_req) begin
        if (w_addrs.size() < 8) w_addrs.push_back(w_addr);
        if (w_stopped) w_late++;
      end
    end
  end

  // One cycle of stimulus: memory response and random grant
  task automatic tick();
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    imem_gnt_i = ($urandom_range(99, 0) < gnt_pct);
    if (mq_due.size() != 0 && mq_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    start_i = 1'b0; inst_ready_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'd0;
    w_start = 1'b0; w_stopped = 1'b0; w_late = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0000_0000);
    chk("rst_valid", 32'(inst_valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", inst_pc_o, 32'd0);
    chk("rst_opcode", 32'(opcode_o), 32'd0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    rst = 1'b0;

    // Straight-line fetch
    tick();
    start_i = 1'b1;
    w_start = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      #2;
      if (i == 2) chk("sl_valid_c2", 32'(inst_valid_o), 32'd0);
      if (i == 3) begin
        chk("sl_valid_c3", 32'(inst_valid_o), 32'd1);
        chk("sl_pc0", inst_pc_o, 32'h0000_0000);
        chk("sl_inst0", inst_o, 32'h00A0_0093);
        chk("sl_opcode0", 32'(opcode_o), 32'h0000_0013);
      end
      if (i == 4) begin
        chk("sl_pc1", inst_pc_o, 32'h0000_0004);
        chk("sl_inst1", inst_o, 32'h0010_8113);
      end
    end

    // Decode stall for 5 cycles with a valid head
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (qpc.size() != 0) found = 1'b1;
    end
    chk("stall_found_head", 32'(found), 32'd1);
    inst_ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) begin
        #2;
        chk("stall_req_full", 32'(imem_req_o), 32'd0);
      end
    end
    tick();
    inst_ready_i = 1'b1;
`ifdef IFU_PERF_CNT_EN
    #2;
    chk("stall_perf", perf_stall_o, 32'd5);
`endif
    repeat (10) tick();

    // Redirect with 2 outstanding, latency 3
    lat_lo = 3; lat_hi = 3;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (m_run && m_outst == 2) begin
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0103;
        found = 1'b1;
      end
    end
    chk("rd2_found", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      #2;
      if (i == 0) chk("rd2_valid_d1", 32'(inst_valid_o), 32'd0);
      if (inst_valid_o) begin
        chk("rd2_first_pc", inst_pc_o, 32'h0000_0100);
        found = 1'b1;
      end
    end
    chk("rd2_delivered", 32'(found), 32'd1);
    repeat (10) tick();

    // Redirect coinciding with rvalid and pop
    lat_lo = 1; lat_hi = 2;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (imem_rvalid_i && qpc.size() != 0) begin
        redirect_i = 1'b1;
        redirect_pc_i = 32'h0000_0200;
        found = 1'b1;
      end
    end
    chk("rdx_found", 32'(found), 32'd1);
    tick();
    #2;
    chk("rdx_valid_next", 32'(inst_valid_o), 32'd0);
    repeat (10) tick();

    // PC wrap via redirect, then stop
    lat_lo = 1; lat_hi = 1;
    tick();
    redirect_i = 1'b1;
    redirect_pc_i = 32'hFFFF_FFF8;
    repeat (12) tick();
    start_i = 1'b0;
    w_start = 1'b0;
    repeat (2) tick();
    w_stopped = 1'b1;
    repeat (10) tick();
    #2;
    chk("stop_req", 32'(imem_req_o), 32'd0);
    if (w_addrs.size() >= 3) begin
      chk("wrap_addr0", w_addrs[0], 32'hFFFF_FFF8);
      chk("wrap_addr1", w_addrs[1], 32'hFFFF_FFFC);
      chk("wrap_addr2", w_addrs[2], 32'h0000_0000);
    end else begin
      n_cmp++;
      n_bad++;
      $display("FAIL wrap_grants: actual=%0d required=3", w_addrs.size());
    end
    chk("wrap_stop_grants", w_late, 32'd0);

    // Asynchronous reset while the queue holds 2
    start_i = 1'b1;
    inst_ready_i = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (qpc.size() == 2) found = 1'b1;
    end
    chk("rr_full", 32'(found), 32'd1);
    #1;
    rst = 1'b1;
    #2;
    chk("rr_req", 32'(imem_req_o), 32'd0);
    chk("rr_addr", imem_addr_o, 32'h0000_0000);
    chk("rr_valid", 32'(inst_valid_o), 32'd0);
    chk("rr_inst", inst_o, 32'd0);
    chk("rr_pc", inst_pc_o, 32'd0);
    chk("rr_opcode", 32'(opcode_o), 32'd0);
`ifdef IFU_PERF_CNT_EN
    chk("rr_perf_f", perf_fetched_o, 32'd0);
    chk("rr_perf_s", perf_stall_o, 32'd0);
`endif
    repeat (2) tick();
    rst = 1'b0;
    inst_ready_i = 1'b1;

    // Random traffic
    gnt_pct = 60; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(99, 0) < 3) start_i = ~start_i;
      inst_ready_i = ($urandom_range(99, 0) < 70);
      if ($urandom_range(99, 0) < 5) begin
        redirect_i = 1'b1;
        redirect_pc_i = $urandom;
      end
    end
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
